// File: rtl/fifo_rd_stream_adapter_if.sv
// Signal bundle between the FIFO read port, fifo_rd_stream_adapter and the downstream stream sink.
// The master modport is the adapter's view; slave is the FIFO/sink side.
interface fifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [1:0]            buf_level;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output rd_en, m_valid, m_data, m_last, buf_level
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  rd_en, m_valid, m_data, m_last, buf_level
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side drain engine: credit-based prefetch into a 3-entry buffer, valid/ready stream out.
// Optional packet framing on m_last is built only when FIFO_RD_STREAM_LAST_EN is defined.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 0,
    parameter int PKT_LEN    = 9
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    fifo_rd_stream_adapter_if.master  bus
);
    localparam int RD_LAT = 1 + OUT_REG;

    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_out_reg
        $error("fifo_rd_stream_adapter: OUT_REG must be 0 or 1");
    end
    if (PKT_LEN < 2 || PKT_LEN > 1023) begin : g_bad_pkt_len
        $error("fifo_rd_stream_adapter: PKT_LEN must be in 2..1023");
    end

    logic [RD_LAT-1:0]     inflight;
    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            level;
    logic [2:0]            inflight_cnt;
    logic [3:0]            credit_use;
    logic                  push;
    logic                  pop;
    logic                  m_valid_int;
    logic                  rd_en_int;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + {2'b00, inflight[i]};
        end
    end

    assign m_valid_int = (level != 2'd0);
    assign push        = inflight[RD_LAT-1];
    assign pop         = m_valid_int & bus.m_ready;

    // Words already requested plus words held must stay within the 3 buffer slots.
    assign credit_use  = {1'b0, inflight_cnt} + {2'b00, level} - {3'b000, pop};
    assign rd_en_int   = rd_rst_n & ~bus.fifo_empty & (credit_use < 4'd3);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight <= '0;
        end else begin
            inflight[0] <= rd_en_int;
            for (int i = 1; i < RD_LAT; i++) begin
                inflight[i] <= inflight[i-1];
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.fifo_rd_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

    assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(push && !pop && level == 2'd3));

    assign bus.rd_en     = rd_en_int;
    assign bus.m_valid   = m_valid_int;
    assign bus.m_data    = mem[rd_ptr];
    assign bus.buf_level = level;

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int CNT_W = $clog2(PKT_LEN);

    logic [CNT_W-1:0] beat_cnt;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == CNT_W'(PKT_LEN - 1)) ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    assign bus.m_last = m_valid_int & (beat_cnt == CNT_W'(PKT_LEN - 1));
`else
    assign bus.m_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: lanes with OUT_REG=0 and OUT_REG=1 drain the same FIFO contents,
// scored against the ordered list of loaded words. Define FIFO_RD_STREAM_LAST_EN to exercise m_last.
`timescale 1ns/1ps
module tb_fifo_rd_stream_adapter;
    localparam int DW  = 32;
    localparam int PKT = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus0 ();
    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus1 ();

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .OUT_REG(0), .PKT_LEN(PKT)) dut0 (
        .rd_clk(clk), .rd_rst_n(rst_n), .bus(bus0)
    );
    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .OUT_REG(1), .PKT_LEN(PKT)) dut1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .bus(bus1)
    );

    logic [DW-1:0] fmem [256];
    int            wr_idx = 0;
    int            rd_idx [2];
    logic [DW-1:0] stage  [2];
    logic [DW-1:0] dly1;

    logic          empty [2];
    logic          ready [2];
    logic          rd_en [2];
    logic          valid [2];
    logic          last  [2];
    logic [DW-1:0] data  [2];
    logic [1:0]    level [2];

    assign empty[0] = (rd_idx[0] == wr_idx);
    assign empty[1] = (rd_idx[1] == wr_idx);

    assign bus0.fifo_empty   = empty[0];
    assign bus1.fifo_empty   = empty[1];
    assign bus0.fifo_rd_data = stage[0];
    assign bus1.fifo_rd_data = dly1;
    assign bus0.m_ready      = ready[0];
    assign bus1.m_ready      = ready[1];

    assign rd_en[0] = bus0.rd_en;     assign rd_en[1] = bus1.rd_en;
    assign valid[0] = bus0.m_valid;   assign valid[1] = bus1.m_valid;
    assign last[0]  = bus0.m_last;    assign last[1]  = bus1.m_last;
    assign data[0]  = bus0.m_data;    assign data[1]  = bus1.m_data;
    assign level[0] = bus0.buf_level; assign level[1] = bus1.buf_level;

    // FIFO read port: one register stage, plus one more for the OUT_REG=1 lane.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                rd_idx[l] <= 0;
                stage[l]  <= '0;
            end
            dly1 <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (rd_en[l] && !empty[l]) begin
                    stage[l]  <= fmem[rd_idx[l]];
                    rd_idx[l] <= rd_idx[l] + 1;
                end
            end
            dly1 <= stage[1];
        end
    end

    logic [DW-1:0] loaded  [$];
    logic [DW-1:0] pending [$];
    int            got       [2];
    int            rd_cnt    [2];
    int            first_pop [2];
    int            last_pop  [2];
    bit            stalled   [2];
    logic [DW-1:0] held      [2];
    int            cyc    = 0;
    int            passes = 0;
    int            fails  = 0;
    int            total  = 0;

    task automatic checkOutput(input string tag, input int lane,
                               input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s lane%0d observed=0x%0h expected=0x%0h", tag, lane, obs, exp);
        end
    endtask

    function automatic logic expLast(input int beat);
        bit en = 1'b0;
`ifdef FIFO_RD_STREAM_LAST_EN
        en = 1'b1;
`endif
        return en && (((beat + 1) % PKT) == 0);
    endfunction

    task automatic scoreCycle();
        for (int l = 0; l < 2; l++) begin
            checkOutput("rd_en_while_empty", l, {31'd0, rd_en[l] & empty[l]}, 0);
            if (stalled[l]) begin
                checkOutput("valid_held", l, {31'd0, valid[l]}, 1);
                checkOutput("data_held", l, data[l], held[l]);
            end
            if (valid[l] && ready[l]) begin
                if (got[l] < loaded.size()) begin
                    checkOutput("data_order", l, data[l], loaded[got[l]]);
                    checkOutput("last_flag", l, {31'd0, last[l]}, {31'd0, expLast(got[l])});
                end else begin
                    checkOutput("extra_word", l, got[l], loaded.size());
                end
                if (first_pop[l] < 0) first_pop[l] = cyc;
                last_pop[l] = cyc;
                got[l]++;
            end
            if (rd_en[l]) rd_cnt[l]++;
            stalled[l] = valid[l] && !ready[l];
            held[l]    = data[l];
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1);
        @(negedge clk);
        cyc++;
        ready[0] = r0;
        ready[1] = r1;
        while (pending.size() != 0) begin
            fmem[wr_idx] = pending[0];
            loaded.push_back(pending.pop_front());
            wr_idx++;
        end
        #1;
        scoreCycle();
    endtask

    task automatic queueWords(input int n, input bit fixed, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            pending.push_back(fixed ? base + DW'(i) : DW'($urandom));
        end
    endtask

    task automatic resetDut(input bit wait_edge);
        if (wait_edge) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            checkOutput("reset_valid", l, {31'd0, valid[l]}, 0);
            checkOutput("reset_level", l, {30'd0, level[l]}, 0);
            checkOutput("reset_rd_en", l, {31'd0, rd_en[l]}, 0);
            checkOutput("reset_data", l, data[l], 0);
            checkOutput("reset_last", l, {31'd0, last[l]}, 0);
            got[l]       = 0;
            stalled[l]   = 1'b0;
            first_pop[l] = -1;
        end
        wr_idx = 0;
        loaded.delete();
        pending.delete();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    // mode 0: sink always ready; 1: ready toggles each cycle; 2: random per lane.
    task automatic drain(input int budget, input int mode);
        int n = 0;
        while ((pending.size() != 0 || got[0] < loaded.size() || got[1] < loaded.size())
               && n < budget) begin
            case (mode)
                1:       applyStimulus(n[0] == 1'b0, n[0] == 1'b0);
                2:       applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: applyStimulus(1'b1, 1'b1);
            endcase
            n++;
        end
        for (int l = 0; l < 2; l++) begin
            checkOutput("all_words_delivered", l, got[l], loaded.size());
        end
    endtask

    initial begin
        int load_cyc;
        int rd_before [2];
        for (int l = 0; l < 2; l++) begin
            ready[l]     = 1'b0;
            got[l]       = 0;
            rd_cnt[l]    = 0;
            first_pop[l] = -1;
            last_pop[l]  = -1;
            stalled[l]   = 1'b0;
        end

        $display("[TB] reset and 5-word burst");
        resetDut(1'b1);
        queueWords(5, 1'b1, 32'h11);
        applyStimulus(1'b1, 1'b1);
        load_cyc = cyc;
        drain(30, 0);
        checkOutput("first_valid_latency", 0, first_pop[0] - load_cyc, 2);
        checkOutput("first_valid_latency", 1, first_pop[1] - load_cyc, 3);
        for (int l = 0; l < 2; l++) begin
            checkOutput("burst_back_to_back", l, last_pop[l] - first_pop[l], 4);
        end
        applyStimulus(1'b1, 1'b1);
        for (int l = 0; l < 2; l++) begin
            checkOutput("idle_rd_en", l, {31'd0, rd_en[l]}, 0);
            checkOutput("idle_level", l, {30'd0, level[l]}, 0);
        end

        $display("[TB] 10 words with toggling ready");
        queueWords(10, 1'b0, '0);
        drain(80, 1);

        $display("[TB] stalled sink with 8 words");
        for (int l = 0; l < 2; l++) rd_before[l] = rd_cnt[l];
        queueWords(8, 1'b0, '0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            checkOutput("stall_rd_pulses", l, rd_cnt[l] - rd_before[l], 3);
            checkOutput("stall_level", l, {30'd0, level[l]}, 3);
            checkOutput("stall_rd_en", l, {31'd0, rd_en[l]}, 0);
            first_pop[l] = -1;
        end
        drain(40, 0);
        for (int l = 0; l < 2; l++) begin
            checkOutput("release_back_to_back", l, last_pop[l] - first_pop[l], 7);
        end

        $display("[TB] 20 random words with random ready");
        queueWords(20, 1'b0, '0);
        drain(300, 2);

        $display("[TB] reset mid-burst");
        queueWords(6, 1'b0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_reset_level", 0, {30'd0, level[0]}, 2);
        resetDut(1'b0);
        queueWords(3, 1'b0, '0);
        drain(30, 0);

        $display("[TB] 18 words for packet framing");
        resetDut(1'b1);
        queueWords(18, 1'b0, '0);
        drain(60, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
